// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit and its ALU decoder.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, EXECUTE, RTYPEWB, MEMADR, MEMREAD, MEMWB,
      MEMWRITE, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RDB   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp/Funct to an ALUControl code; valid drops for unsupported Funct values.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [5:0] Funct,
   output logic [3:0] ALUControl,
   output logic       valid
);

   always_comb begin
      ALUControl = '0;
      valid      = 1'b0;
      case (ALUOp)
         ALUOP_ADD: begin ALUControl = ALU_ADD; valid = 1'b1; end
         ALUOP_SUB: begin ALUControl = ALU_SUB; valid = 1'b1; end
         ALUOP_FUNCT: begin
            valid = 1'b1;
            case (Funct)
               FN_ADD:  ALUControl = ALU_ADD;
               FN_SUB:  ALUControl = ALU_SUB;
               FN_AND:  ALUControl = ALU_AND;
               FN_OR:   ALUControl = ALU_OR;
               FN_SLT:  ALUControl = ALU_SLT;
               FN_NOR:  ALUControl = ALU_NOR;
               default: valid = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle Moore control FSM with mem_ready handshake, optional wait timeout and trap.
// Define CTRL_PERF_CNT_EN to add the cycle_count/instr_retired performance counters.
module multi_cycle_control
   import ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int TMO_W          = 8
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic [3:0] ALUControl,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       halted
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_retired
`endif
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [TMO_W-1:0] wait_q, wait_d;
   logic             halted_q, halted_d;
   logic [1:0]       alu_op;
   logic             alu_en, alu_valid, tmo_hit, mem_state, unused_zero;
   logic [3:0]       alu_ctrl;

   // Zero gates the PC load inside the datapath via PCWriteCond; control never consumes it.
   always_comb unused_zero = Zero;

   always_comb begin
      alu_op = ALUOP_ADD;
      alu_en = 1'b0;
      case (state_q)
         FETCH, DECODE, MEMADR, ADDIEX: alu_en = 1'b1;
         EXECUTE: begin alu_op = ALUOP_FUNCT; alu_en = 1'b1; end
         BRANCH:  begin alu_op = ALUOP_SUB;   alu_en = 1'b1; end
         default: ;
      endcase
   end

   alu_decoder u_alu_decoder (
      .ALUOp      (alu_op),
      .Funct      (Funct),
      .ALUControl (alu_ctrl),
      .valid      (alu_valid)
   );

   always_comb begin
      mem_state = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
      tmo_hit   = (TIMEOUT_CYCLES != 0) && (wait_q == TMO_LAST);
   end

   always_comb begin
      state_d     = state_q;
      ALUControl  = alu_en ? alu_ctrl : '0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RDB;
      PCSource    = PCSRC_ALU;
      halted      = halted_q;
      case (state_q)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready)    state_d = DECODE;
            else if (tmo_hit) state_d = TRAP;
         end
         DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            case (Opcode)
               OP_RTYPE:     state_d = EXECUTE;
               OP_LW, OP_SW: state_d = MEMADR;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default:      state_d = TRAP;
            endcase
         end
         EXECUTE: begin
            ALUSrcA = 1'b1;
            state_d = alu_valid ? RTYPEWB : TRAP;
         end
         RTYPEWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            state_d  = FETCH;
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = (Opcode == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready)    state_d = MEMWB;
            else if (tmo_hit) state_d = TRAP;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            state_d  = FETCH;
         end
         MEMWRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready)    state_d = FETCH;
            else if (tmo_hit) state_d = TRAP;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            state_d     = FETCH;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = ADDIWB;
         end
         ADDIWB: begin
            RegWrite = 1'b1;
            state_d  = FETCH;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
            state_d  = FETCH;
         end
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
      // Reset overrides every strobe combinationally, so an aborted request never leaks out.
      if (!reset) begin
         ALUControl  = '0;
         RegWrite    = 1'b0;
         RegDst      = 1'b0;
         MemtoReg    = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IorD        = 1'b0;
         IRWrite     = 1'b0;
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         ALUSrcA     = 1'b0;
         ALUSrcB     = '0;
         PCSource    = '0;
         halted      = 1'b0;
      end
   end

   always_comb begin
      wait_d = '0;
      if (mem_state && !mem_ready && (state_d == state_q))
         wait_d = (wait_q == '1) ? wait_q : wait_q + TMO_W'(1);
      halted_d = halted_q || (state_d == TRAP);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= FETCH;
         wait_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         halted_q <= halted_d;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cyc_q, cyc_d, ret_q, ret_d;

   always_comb begin
      cyc_d         = halted_q ? cyc_q : cyc_q + 32'd1;
      ret_d         = ((state_d == FETCH) && (state_q != FETCH)) ? ret_q + 32'd1 : ret_q;
      cycle_count   = reset ? cyc_q : '0;
      instr_retired = reset ? ret_q : '0;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ret_q <= ret_d;
      end
   end
`endif

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Control-side partner of the CPU datapath: consumes Opcode/Funct/Zero from the datapath and drives every datapath control strobe.
- Replaces fixed single-cycle control with a multi-cycle Moore FSM: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
- Memory accesses use a ready handshake, so variable-latency memory can sit behind the datapath.
- Supports R-type add/sub/and/or/slt/nor, lw, sw, beq, addi, j; anything else traps.

Parameters:
- TIMEOUT_CYCLES, 0: maximum cycles to wait for mem_ready in any memory state; 0 disables the timeout.
- TMO_W, 8: width of the wait counter; TIMEOUT_CYCLES must be less than 2**TMO_W.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- Opcode  in  6  instruction[31:26] from the datapath instruction register.
- Funct  in  6  instruction[5:0].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- ALUControl  out  4  ALU operation.
- RegWrite  out  1  register file write enable.
- RegDst  out  1  write address select: 1 = rd, 0 = rt.
- MemtoReg  out  1  write data select: 1 = MDR, 0 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when Zero=1.
- ALUSrcA  out  1  0 = PC, 1 = rdA.
- ALUSrcB  out  2  00 = rdB, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- halted  out  1  sticky trap indicator.

Behaviour:
- Reset (reset==0 at a clock edge): state <= FETCH, wait counter <= 0, halted <= 0. All outputs are forced to 0 in every cycle where reset==0; this holds regardless of state, including reset mid-instruction.
- Outputs are decoded from state (Moore), except the FETCH strobes below, which are gated by mem_ready.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
  - IRWrite=PCWrite=mem_ready.
  - Goes to DECODE when mem_ready=1; otherwise holds.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut). Next state by Opcode:
  - 000000 -> EXECUTE.
  - 100011 or 101011 -> MEMADR.
  - 000100 -> BRANCH.
  - 001000 -> ADDIEX.
  - 000010 -> JUMP.
  - anything else -> TRAP.
- EXECUTE:
  - ALUSrcA=1, ALUSrcB=00, ALUControl from Funct.
  - Funct mapping: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR.
  - Known Funct -> RTYPEWB; any other Funct -> TRAP.
- RTYPEWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: MemRead=1, IorD=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Holds until mem_ready, then -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=01 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- TRAP: all strobes 0, halted=1; state is absorbing until reset.
- ALUControl encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- Latency with zero-wait memory: beq/j 3 cycles; R-type/addi/sw 4 cycles; lw 5 cycles. Each mem_ready wait cycle adds one cycle.
- Timeout:
  - The wait counter increments in any memory state while mem_ready=0 and clears on leaving that state.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, the next state is TRAP.
  - If mem_ready=1 arrives in the same cycle the limit is reached, mem_ready wins.
- Requests are level-held: MemRead/MemWrite stay high until the cycle in which mem_ready=1. mem_ready outside a memory state is ignored.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined, adds outputs cycle_count[31:0] and instr_retired[31:0]:
  - cycle_count increments on every non-reset cycle while halted==0.
  - instr_retired increments on each transition into FETCH from a completing state.
  - Both clear on reset and wrap modulo 2**32.
- When undefined, neither port nor counter exists and the remaining behaviour is identical.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants;
  - ALUControl encodings;
  - ALUSrcB/PCSource select constants.
- Sub-module alu_decoder: combinational, inputs ALUOp[1:0] (00 add, 01 sub, 10 funct) and Funct; outputs ALUControl and a valid flag. The FSM uses the valid flag for the EXECUTE -> TRAP decision.

Test Plan:
- add (Opcode 000000, Funct 100000), mem_ready tied 1 -> states FETCH, DECODE, EXECUTE, RTYPEWB; ALUControl 0010 in EXECUTE; RegWrite=1, RegDst=1 for exactly 1 cycle; 4 cycles total.
- lw (100011), mem_ready delayed 3 cycles in MEMREAD -> MemRead/IorD held 4 cycles; MEMWB asserts RegWrite=1, MemtoReg=1; 8 cycles total.
- beq (000100) with Zero=1, then with Zero=0 -> PCWriteCond=1, PCSource=01, ALUControl=0110 in BRANCH in both runs; returns to FETCH after 3 cycles.
- Opcode 111111, and separately R-type Funct 000000 -> TRAP reached; halted=1 and all strobes 0 for 20 further cycles; a reset=0 pulse returns to FETCH with halted=0.
- TIMEOUT_CYCLES=5, mem_ready held 0 during FETCH -> TRAP after 5 wait cycles; repeat with mem_ready=1 on the 5th cycle -> DECODE, no trap.
- reset=0 asserted during MEMWRITE -> all outputs 0 that cycle; after release, state FETCH; MemWrite never re-asserts for the aborted sw.
